icache_direct: RTL

- Direct-mapped, one-word-per-line instruction cache between the instruction fetcher (upstream) and the memory controller's instruction port (downstream).
- Hits return the 32-bit instruction one cycle after the request.
- Misses issue a single word fetch to the memory controller, hold it until the done pulse, fill the line, then answer the fetcher.
- On a pipeline clear the outstanding miss is abandoned; array contents are kept.

---
 rtl/icache_direct_pkg.sv | 21 ++
 rtl/icache_direct_array.sv | 58 +++++
 rtl/icache_direct.sv | 131 +++++++++++++
 3 files changed

// File: rtl/icache_direct_pkg.sv
// -----------------------------------------------------------------------------
// icache_direct_pkg
// Shared definitions for the direct-mapped instruction cache:
//   INST_SIZE     - instruction / memory word width
//   ic_state_e    - controller states (IC_IDLE, IC_MISS)
//   word_align()  - forces a byte address onto a word boundary
// -----------------------------------------------------------------------------
package icache_direct_pkg;

   localparam int INST_SIZE = 32;

   typedef enum logic [0:0] {
      IC_IDLE = 1'b0,
      IC_MISS = 1'b1
   } ic_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage : icache_direct_pkg

// File: rtl/icache_direct_array.sv
// -----------------------------------------------------------------------------
// icache_direct_array
// Valid/tag/data storage for the direct-mapped cache. One synchronous write
// port, one combinational read port. Only the valid bits are reset; tag and
// data contents are meaningless until their valid bit is set.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_we                 write enable (line fill)
//   i_waddr/i_wtag/i_wdata  fill index, tag and instruction word
//   i_raddr              lookup index
//   o_rvalid/o_rtag/o_rdata  lookup result
// -----------------------------------------------------------------------------
module icache_direct_array
   import icache_direct_pkg::*;
#(
   parameter int INDEX_BITS = 8,
   parameter int TAG_BITS   = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [INDEX_BITS-1:0] i_waddr,
   input  logic [TAG_BITS-1:0]   i_wtag,
   input  logic [INST_SIZE-1:0]  i_wdata,
   input  logic [INDEX_BITS-1:0] i_raddr,
   output logic                  o_rvalid,
   output logic [TAG_BITS-1:0]   o_rtag,
   output logic [INST_SIZE-1:0]  o_rdata
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]     r_valid;
   logic [TAG_BITS-1:0]  r_tag  [LINES];
   logic [INST_SIZE-1:0] r_data [LINES];

   // Valid bits: cleared by reset, set on each line fill.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_waddr] <= 1'b1;
      end
   end

   // Tag/data storage: no reset so it can map onto RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_tag[i_waddr]  <= i_wtag;
         r_data[i_waddr] <= i_wdata;
      end
   end

   assign o_rvalid = r_valid[i_raddr];
   assign o_rtag   = r_tag[i_raddr];
   assign o_rdata  = r_data[i_raddr];

endmodule : icache_direct_array

// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
// Direct-mapped, one-word-per-line instruction cache between the fetcher and
// the memory controller instruction port. Hits answer one cycle after the
// request; misses fetch one word, fill the line, then answer.
// Ports:
//   clk_in, rst_n_in      clock, async active-low reset
//   rdy_in                global ready; low freezes all state
//   clear                 pipeline flush, abandons any pending miss
//   fetch_en_i/fetch_pc_i fetch request
//   fetch_valid_o/fetch_inst_o  one-cycle response pulse and instruction
//   mem_req_o/mem_addr_o  word read request to memory
//   mem_done_i/mem_data_i memory completion pulse and data
// -----------------------------------------------------------------------------
module icache_direct
   import icache_direct_pkg::*;
#(
   parameter int INDEX_BITS = 8,
   parameter int ADDR_BITS  = 18
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 fetch_en_i,
   input  logic [31:0]          fetch_pc_i,
   output logic                 fetch_valid_o,
   output logic [INST_SIZE-1:0] fetch_inst_o,
   output logic                 mem_req_o,
   output logic [31:0]          mem_addr_o,
   input  logic                 mem_done_i,
   input  logic [INST_SIZE-1:0] mem_data_i
);

   localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

   ic_state_e              r_state;
   logic [ADDR_BITS-1:2]   r_pc;

   logic [INDEX_BITS-1:0]  w_req_index;
   logic [TAG_BITS-1:0]    w_req_tag;
   logic [INDEX_BITS-1:0]  w_fill_index;
   logic [TAG_BITS-1:0]    w_fill_tag;
   logic                   w_rvalid;
   logic [TAG_BITS-1:0]    w_rtag;
   logic [INST_SIZE-1:0]   w_rdata;
   logic                   w_hit;
   logic                   w_we;
   logic                   w_unused;

   assign w_req_index  = fetch_pc_i[INDEX_BITS+1:2];
   assign w_req_tag    = fetch_pc_i[ADDR_BITS-1:INDEX_BITS+2];
   assign w_fill_index = r_pc[INDEX_BITS+1:2];
   assign w_fill_tag   = r_pc[ADDR_BITS-1:INDEX_BITS+2];
   assign w_hit        = w_rvalid && (w_rtag == w_req_tag);
   assign w_unused     = &{1'b0, fetch_pc_i[1:0]};

   // The fill happens even when clear arrives with done: the word is genuine
   // memory content, only the response is dropped.
   assign w_we = rdy_in && (r_state == IC_MISS) && mem_done_i;

   icache_direct_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .i_clk    (clk_in),
      .i_rst_n  (rst_n_in),
      .i_we     (w_we),
      .i_waddr  (w_fill_index),
      .i_wtag   (w_fill_tag),
      .i_wdata  (mem_data_i),
      .i_raddr  (w_req_index),
      .o_rvalid (w_rvalid),
      .o_rtag   (w_rtag),
      .o_rdata  (w_rdata)
   );

   // Controller FSM with registered fetch/memory outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state       <= IC_IDLE;
         r_pc          <= '0;
         fetch_valid_o <= 1'b0;
         fetch_inst_o  <= '0;
         mem_req_o     <= 1'b0;
         mem_addr_o    <= 32'h0000_0000;
      end else if (!rdy_in) begin
         r_state <= r_state;
      end else if (clear) begin
         // Flush wins over any same-cycle request; no lookup this cycle.
         r_state       <= IC_IDLE;
         fetch_valid_o <= 1'b0;
         mem_req_o     <= 1'b0;
      end else begin
         case (r_state)
            IC_IDLE: begin
               if (fetch_en_i && w_hit) begin
                  fetch_valid_o <= 1'b1;
                  fetch_inst_o  <= w_rdata;
               end else if (fetch_en_i) begin
                  fetch_valid_o <= 1'b0;
                  r_pc          <= fetch_pc_i[ADDR_BITS-1:2];
                  mem_req_o     <= 1'b1;
                  mem_addr_o    <= word_align(fetch_pc_i);
                  r_state       <= IC_MISS;
               end else begin
                  fetch_valid_o <= 1'b0;
               end
            end
            IC_MISS: begin
               // Request must drop on the edge after done so memory does not
               // re-issue while it returns to idle.
               if (mem_done_i) begin
                  fetch_valid_o <= 1'b1;
                  fetch_inst_o  <= mem_data_i;
                  mem_req_o     <= 1'b0;
                  r_state       <= IC_IDLE;
               end else begin
                  fetch_valid_o <= 1'b0;
               end
            end
            default: begin
               r_state       <= IC_IDLE;
               fetch_valid_o <= 1'b0;
               mem_req_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule : icache_direct
